// File: rtl/ex_fp_pipe.sv
// Pipelined FP execution unit: oldest-ready reservation-station pick, LAT-stage
// floating datapath, ready/valid result port with FP register-file write and flush.
module ex_fp_pipe #(
    parameter int          NUM_RS     = 2,
    parameter int          DATA_W     = 32,
    parameter int          OP_W       = 5,
    parameter int          ADDR_W     = 5,
    parameter int          ROB_W      = 4,
    parameter int          AGE_W      = 4,
    parameter int          LAT        = 3,
    parameter logic [2:0]  ROUND_MODE = 3'b000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [NUM_RS-1:0]          rs_valid,
    input  logic [NUM_RS-1:0]          rs_src1_rdy,
    input  logic [NUM_RS-1:0]          rs_src2_rdy,
    input  logic [NUM_RS*DATA_W-1:0]   rs_src1,
    input  logic [NUM_RS*DATA_W-1:0]   rs_src2,
    input  logic [NUM_RS*OP_W-1:0]     rs_op,
    input  logic [NUM_RS*ADDR_W-1:0]   rs_wraddr,
    input  logic [NUM_RS-1:0]          rs_regwrite,
    input  logic [NUM_RS*ROB_W-1:0]    rs_rob_num,
    input  logic [NUM_RS*AGE_W-1:0]    rs_age,
    output logic [NUM_RS-1:0]          rs_issue,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_result,
    output logic [ADDR_W-1:0]          out_wraddr,
    output logic                       out_regwrite,
    output logic [ROB_W-1:0]           out_rob_num,
    output logic [DATA_W-1:0]          writedata_fp,
    output logic [ADDR_W-1:0]          writeaddr_fp,
    output logic                       writeen_fp
);

    typedef struct packed {
        logic [ADDR_W-1:0] wraddr;
        logic              regwrite;
        logic [ROB_W-1:0]  rob_num;
    } meta_t;

    logic              cand_any, issue_en, advance;
    logic [NUM_RS-1:0] sel_oh;
    logic [AGE_W-1:0]  best_age;
    logic [OP_W-1:0]   sel_op, op_q;
    logic [DATA_W-1:0] sel_a, sel_b, a_q, b_q, fp_res;
    meta_t             sel_meta;
    meta_t             meta_q [1:LAT];
    logic [LAT:1]      vld_pipe;

    // Strict '<' keeps the lowest index on equal ages.
    always_comb begin
        cand_any = 1'b0;
        best_age = '0;
        sel_oh   = '0;
        sel_op   = '0;
        sel_a    = '0;
        sel_b    = '0;
        sel_meta = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            if (rs_valid[i] && rs_src1_rdy[i] && rs_src2_rdy[i] &&
                (!cand_any || rs_age[i*AGE_W +: AGE_W] < best_age)) begin
                cand_any          = 1'b1;
                best_age          = rs_age[i*AGE_W +: AGE_W];
                sel_oh            = '0;
                sel_oh[i]         = 1'b1;
                sel_op            = rs_op[i*OP_W +: OP_W];
                sel_a             = rs_src1[i*DATA_W +: DATA_W];
                sel_b             = rs_src2[i*DATA_W +: DATA_W];
                sel_meta.wraddr   = rs_wraddr[i*ADDR_W +: ADDR_W];
                sel_meta.regwrite = rs_regwrite[i];
                sel_meta.rob_num  = rs_rob_num[i*ROB_W +: ROB_W];
            end
        end
    end

    assign advance  = !(out_valid && !out_ready);
    assign issue_en = cand_any && advance && !flush && !rst;
    assign rs_issue = issue_en ? sel_oh : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            for (int k = 1; k <= LAT; k++) meta_q[k] <= '0;
        end else begin
            if (advance) begin
                if (issue_en) begin
                    op_q      <= sel_op;
                    a_q       <= sel_a;
                    b_q       <= sel_b;
                    meta_q[1] <= sel_meta;
                end
                for (int k = LAT; k >= 2; k--) meta_q[k] <= meta_q[k-1];
            end
            if (flush) begin
                vld_pipe <= '0;
            end else if (advance) begin
                for (int k = LAT; k >= 2; k--) vld_pipe[k] <= vld_pipe[k-1];
                vld_pipe[1] <= issue_en;
            end
        end
    end

    floating u_fp (
        .aluop  (op_q),
        .a      (a_q),
        .b      (b_q),
        .mode   (ROUND_MODE),
        .result (fp_res)
    );

    generate
        if (LAT == 1) begin : g_lat1
            assign out_result = fp_res;
        end else begin : g_latn
            // res_q[0] is stage 2, res_q[LAT-2] is the output stage.
            logic [DATA_W-1:0] res_q [LAT-1];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < LAT-1; k++) res_q[k] <= '0;
                end else if (advance) begin
                    res_q[0] <= fp_res;
                    for (int k = LAT-2; k >= 1; k--) res_q[k] <= res_q[k-1];
                end
            end
            assign out_result = res_q[LAT-2];
        end
    endgenerate

    assign out_valid    = vld_pipe[LAT];
    assign out_wraddr   = meta_q[LAT].wraddr;
    assign out_regwrite = meta_q[LAT].regwrite;
    assign out_rob_num  = meta_q[LAT].rob_num;
    assign writedata_fp = out_result;
    assign writeaddr_fp = out_wraddr;
    assign writeen_fp   = out_valid && out_regwrite && out_ready && !flush;

endmodule

// Single-precision add/sub/mul. Denormal inputs/results flush to zero, overflow
// saturates to infinity, NaN/inf inputs are not special-cased. mode 0 = RNE, else truncate.
module floating (
    input  logic [4:0]  aluop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  mode,
    output logic [31:0] result
);
    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_MUL = 5'd2;

    logic              sa, sb, swap, ls, res_sign, up, found, is_fp;
    logic [7:0]        ea, eb, le, se, d;
    logic [23:0]       ma, mb, lm, sm;
    logic [4:0]        dcl, lz;
    logic [55:0]       sh;
    logic [27:0]       sm_al, lm_x, s;
    logic [47:0]       p;
    logic signed [9:0] e, ne;
    logic [26:0]       n;
    logic [24:0]       mr;
    logic [22:0]       frac;

    always_comb begin
        sa    = a[31];
        ea    = a[30:23];
        ma    = (ea != 8'd0) ? {1'b1, a[22:0]} : 24'd0;
        sb    = b[31] ^ (aluop == OP_SUB);
        eb    = b[30:23];
        mb    = (eb != 8'd0) ? {1'b1, b[22:0]} : 24'd0;
        swap  = {eb, mb} > {ea, ma};
        le    = swap ? eb : ea;
        se    = swap ? ea : eb;
        lm    = swap ? mb : ma;
        sm    = swap ? ma : mb;
        ls    = swap ? sb : sa;
        d     = le - se;
        dcl   = (d > 8'd31) ? 5'd31 : d[4:0];
        // Bits shifted out of the aligned operand collapse into the sticky bit.
        sh    = {1'b0, sm, 3'b000, 28'd0} >> dcl;
        sm_al = {sh[55:29], sh[28] | (|sh[27:0])};
        lm_x  = {1'b0, lm, 3'b000};
        p     = {24'd0, ma} * {24'd0, mb};

        is_fp    = 1'b1;
        s        = '0;
        e        = '0;
        res_sign = 1'b0;
        if (aluop == OP_MUL) begin
            s        = {p[47:21], |p[20:0]};
            e        = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
            res_sign = a[31] ^ b[31];
        end else if (aluop == OP_ADD || aluop == OP_SUB) begin
            s        = (sa ^ sb) ? (lm_x - sm_al) : (lm_x + sm_al);
            e        = $signed({2'b00, le});
            res_sign = ls;
        end else begin
            is_fp = 1'b0;
        end

        lz    = '0;
        found = 1'b0;
        for (int k = 26; k >= 0; k--) begin
            if (!found && s[k]) begin
                lz    = 5'(26 - k);
                found = 1'b1;
            end
        end
        if (s[27]) begin
            n  = {s[27:2], s[1] | s[0]};
            ne = e + 10'sd1;
        end else begin
            n  = s[26:0] << lz;
            ne = e - $signed({5'b00000, lz});
        end

        up = (mode == 3'b000) && n[2] && ((|n[1:0]) || n[3]);
        mr = {1'b0, n[26:3]} + {24'd0, up};
        if (mr[24]) begin
            frac = mr[23:1];
            ne   = ne + 10'sd1;
        end else begin
            frac = mr[22:0];
        end

        if (!is_fp || s == 28'd0)  result = 32'd0;
        else if (ne >= 10'sd255)   result = {res_sign, 8'hFF, 23'd0};
        else if (ne <= 10'sd0)     result = {res_sign, 31'd0};
        else                       result = {res_sign, ne[7:0], frac};
    end
endmodule

// File: tb/tb_ex_fp_pipe.sv
// Directed bench for ex_fp_pipe: arbitration, gating, latency, backpressure, flush, reset.
module tb_ex_fp_pipe;
    localparam int NUM_RS = 2, DATA_W = 32, OP_W = 5, ADDR_W = 5, ROB_W = 4, AGE_W = 4, LAT = 3;
    localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, MUL = 5'd2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst, flush, out_ready;
    logic [NUM_RS-1:0]        rs_valid, rs_src1_rdy, rs_src2_rdy, rs_regwrite, rs_issue;
    logic [NUM_RS*DATA_W-1:0] rs_src1, rs_src2;
    logic [NUM_RS*OP_W-1:0]   rs_op;
    logic [NUM_RS*ADDR_W-1:0] rs_wraddr;
    logic [NUM_RS*ROB_W-1:0]  rs_rob_num;
    logic [NUM_RS*AGE_W-1:0]  rs_age;
    logic                     out_valid, out_regwrite, writeen_fp;
    logic [DATA_W-1:0]        out_result, writedata_fp;
    logic [ADDR_W-1:0]        out_wraddr, writeaddr_fp;
    logic [ROB_W-1:0]         out_rob_num;

    int n_chk = 0;
    int n_fail = 0;

    ex_fp_pipe #(
        .NUM_RS(NUM_RS), .DATA_W(DATA_W), .OP_W(OP_W), .ADDR_W(ADDR_W),
        .ROB_W(ROB_W), .AGE_W(AGE_W), .LAT(LAT), .ROUND_MODE(3'b000)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .rs_valid(rs_valid), .rs_src1_rdy(rs_src1_rdy), .rs_src2_rdy(rs_src2_rdy),
        .rs_src1(rs_src1), .rs_src2(rs_src2), .rs_op(rs_op), .rs_wraddr(rs_wraddr),
        .rs_regwrite(rs_regwrite), .rs_rob_num(rs_rob_num), .rs_age(rs_age),
        .rs_issue(rs_issue), .out_ready(out_ready), .out_valid(out_valid),
        .out_result(out_result), .out_wraddr(out_wraddr), .out_regwrite(out_regwrite),
        .out_rob_num(out_rob_num), .writedata_fp(writedata_fp),
        .writeaddr_fp(writeaddr_fp), .writeen_fp(writeen_fp)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clr_rs();
        rs_valid = '0; rs_src1_rdy = '0; rs_src2_rdy = '0; rs_regwrite = '0;
        rs_src1 = '0; rs_src2 = '0; rs_op = '0; rs_wraddr = '0; rs_rob_num = '0; rs_age = '0;
    endtask

    task automatic set_ent(input int i, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] wr, input logic rw,
                           input logic [3:0] rob, input logic [3:0] age);
        rs_valid[i] = 1'b1; rs_src1_rdy[i] = 1'b1; rs_src2_rdy[i] = 1'b1;
        rs_src1[i*DATA_W +: DATA_W] = a;
        rs_src2[i*DATA_W +: DATA_W] = b;
        rs_op[i*OP_W +: OP_W] = op;
        rs_wraddr[i*ADDR_W +: ADDR_W] = wr;
        rs_regwrite[i] = rw;
        rs_rob_num[i*ROB_W +: ROB_W] = rob;
        rs_age[i*AGE_W +: AGE_W] = age;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_out(input string tag, input logic [31:0] res, input logic [3:0] rob);
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_result"}, out_result, res);
        chk({tag, "_rob"}, out_rob_num, rob);
    endtask

    logic [4:0]  bp_op  [4] = '{ADD, ADD, MUL, ADD};
    logic [31:0] bp_a   [4] = '{32'h3F800000, 32'h40000000, 32'h40000000, 32'h3F800000};
    logic [31:0] bp_b   [4] = '{32'h40000000, 32'h40800000, 32'h40400000, 32'h40800000};
    logic [31:0] bp_res [4] = '{32'h40400000, 32'h40C00000, 32'h40C00000, 32'h40A00000};
    logic        bp_rw  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        int head, got;
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        clr_rs();
        set_ent(0, ADD, 32'h3F800000, 32'h3F800000, 5'd1, 1'b1, 4'd1, 4'd0);
        @(negedge clk);
        chk("rst_no_issue", rs_issue, 2'b00);
        next_cyc();
        clr_rs();
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        next_cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_rob", out_rob_num, 4'd0);
        chk("rst_out_wraddr", out_wraddr, 5'd0);
        chk("rst_writeen", writeen_fp, 1'b0);
        next_cyc();

        // single op: 1.0 + 2.0
        set_ent(0, ADD, 32'h3F800000, 32'h40000000, 5'd3, 1'b1, 4'd5, 4'd0);
        @(negedge clk);
        chk("single_issue", rs_issue, 2'b01);
        next_cyc(); clr_rs();
        next_cyc();
        @(negedge clk);
        chk("single_c2_idle", out_valid, 1'b0);
        next_cyc();
        @(negedge clk);
        exp_out("single", 32'h40400000, 4'd5);
        chk("single_writeen", writeen_fp, 1'b1);
        chk("single_writeaddr", writeaddr_fp, 5'd3);
        chk("single_writedata", writedata_fp, 32'h40400000);
        next_cyc();
        @(negedge clk);
        chk("single_c4_idle", out_valid, 1'b0);
        next_cyc();

        // age arbitration
        set_ent(0, ADD, 32'h3F800000, 32'h40000000, 5'd1, 1'b1, 4'd0, 4'd7);
        set_ent(1, ADD, 32'h40000000, 32'h40800000, 5'd2, 1'b1, 4'd1, 4'd2);
        @(negedge clk);
        chk("age_older_wins", rs_issue, 2'b10);
        next_cyc();
        rs_age[3:0] = 4'd2;
        @(negedge clk);
        chk("age_tie_low_idx", rs_issue, 2'b01);
        next_cyc(); clr_rs();
        next_cyc();
        @(negedge clk);
        exp_out("age_first", 32'h40C00000, 4'd1);
        next_cyc();
        @(negedge clk);
        exp_out("age_second", 32'h40400000, 4'd0);
        next_cyc();

        // operand gating: entry 1 waits on src2
        set_ent(1, SUB, 32'h40400000, 32'h3F800000, 5'd4, 1'b1, 4'd7, 4'd0);
        rs_src2_rdy[1] = 1'b0;
        @(negedge clk);
        chk("gate_no_issue0", rs_issue, 2'b00);
        next_cyc();
        @(negedge clk);
        chk("gate_no_issue1", rs_issue, 2'b00);
        chk("gate_no_output", out_valid, 1'b0);
        next_cyc();
        rs_src2_rdy[1] = 1'b1;
        @(negedge clk);
        chk("gate_issue_on_rdy", rs_issue, 2'b10);
        next_cyc(); clr_rs();
        next_cyc(); next_cyc();
        @(negedge clk);
        exp_out("gate_sub", 32'h40000000, 4'd7);
        next_cyc();

        // backpressure: 4-op stream, out_ready low in cycles 3 and 4
        head = 0; got = 0;
        for (int c = 0; c < 15; c++) begin
            out_ready = !(c == 3 || c == 4);
            clr_rs();
            if (head < 4)
                set_ent(0, bp_op[head], bp_a[head], bp_b[head], 5'(10 + head), bp_rw[head],
                        4'(1 + head), 4'd0);
            @(negedge clk);
            if (!out_ready) begin
                chk("bp_stall_issue", rs_issue, 2'b00);
                chk("bp_hold_valid", out_valid, 1'b1);
                chk("bp_hold_result", out_result, 32'h40400000);
                chk("bp_hold_rob", out_rob_num, 4'd1);
                chk("bp_stall_writeen", writeen_fp, 1'b0);
            end else if (out_valid) begin
                if (got < 4) begin
                    chk("bp_result", out_result, bp_res[got]);
                    chk("bp_rob", out_rob_num, 4'(1 + got));
                    chk("bp_writeen", writeen_fp, bp_rw[got]);
                    chk("bp_writeaddr", writeaddr_fp, 5'(10 + got));
                    got++;
                end else begin
                    chk("bp_duplicate", out_valid, 1'b0);
                end
            end
            if (rs_issue[0]) head++;
            next_cyc();
        end
        out_ready = 1'b1;
        clr_rs();
        chk("bp_delivered", got, 4);
        chk("bp_issued", head, 4);

        // flush with two ops in flight
        set_ent(0, ADD, 32'h3F800000, 32'h3F800000, 5'd5, 1'b1, 4'd2, 4'd0);
        next_cyc();
        next_cyc();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_no_issue", rs_issue, 2'b00);
        next_cyc();
        flush = 1'b0; clr_rs();
        for (int c = 3; c <= 5; c++) begin
            @(negedge clk);
            chk("flush_out_valid", out_valid, 1'b0);
            next_cyc();
        end

        // flush in the cycle a result is presented: not written
        set_ent(0, ADD, 32'h40000000, 32'h40000000, 5'd6, 1'b1, 4'd3, 4'd0);
        next_cyc(); clr_rs();
        next_cyc(); next_cyc();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_out_present", out_valid, 1'b1);
        chk("flush_writeen", writeen_fp, 1'b0);
        next_cyc();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_killed", out_valid, 1'b0);
        next_cyc();

        // reset mid-stream, then a fresh op
        set_ent(0, ADD, 32'h3F800000, 32'h40000000, 5'd7, 1'b1, 4'd4, 4'd0);
        next_cyc(); next_cyc();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_no_issue", rs_issue, 2'b00);
        next_cyc();
        rst = 1'b0;
        clr_rs();
        set_ent(0, ADD, 32'h40800000, 32'h40800000, 5'd6, 1'b1, 4'd9, 4'd0);
        @(negedge clk);
        chk("rst_mid_valid", out_valid, 1'b0);
        chk("rst_mid_result", out_result, 32'd0);
        chk("rst_mid_rob", out_rob_num, 4'd0);
        chk("rst_mid_wraddr", out_wraddr, 5'd0);
        chk("rst_mid_regwrite", out_regwrite, 1'b0);
        chk("rst_mid_writeen", writeen_fp, 1'b0);
        chk("rst_fresh_issue", rs_issue, 2'b01);
        next_cyc(); clr_rs();
        for (int c = 4; c <= 5; c++) begin
            @(negedge clk);
            chk("rst_old_gone", out_valid, 1'b0);
            next_cyc();
        end
        @(negedge clk);
        exp_out("rst_fresh", 32'h41000000, 4'd9);
        chk("rst_fresh_writeaddr", writeaddr_fp, 5'd6);
        next_cyc();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
